// File: rtl/hdmi_pll_supervisor_if.sv
// ============================================================================
// Module      : hdmi_pll_supervisor_if
// Description : Control/status bundle between the HDMI PLL supervisor and its
//               surroundings (lock input, delay strobes, status outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hdmi_pll_supervisor_if;
  logic       pll_locked;
  logic       delay_inc;
  logic       delay_dec;
  logic       clear_status;
  logic [3:0] pll_delay;
  logic       hdmi_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lost_count;

  modport master (
    output pll_locked, delay_inc, delay_dec, clear_status,
    input  pll_delay, hdmi_reset, ready, lock_lost, lost_count
  );

  modport slave (
    input  pll_locked, delay_inc, delay_dec, clear_status,
    output pll_delay, hdmi_reset, ready, lock_lost, lost_count
  );
endinterface

`default_nettype wire

// File: rtl/hdmi_pll_supervisor.sv
// ============================================================================
// Module      : hdmi_pll_supervisor
// Description : Qualifies HDMI PLL lock, gates the HDMI-domain reset, owns the
//               PLL dynamic feedback delay and keeps lock-loss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_pll_supervisor #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter logic [3:0]  DELAY_INIT    = 4'd0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  hdmi_pll_supervisor_if.slave  bus
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STABLE    = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_SETTLE    = 2'd3;

  logic          sync1_q;
  logic          lk_q;
  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [3:0]    delay_q,     delay_d;
  logic          hrst_q,      hrst_d;
  logic          ready_q,     ready_d;
  logic          lock_lost_q, lock_lost_d;
  logic [7:0]    lost_cnt_q,  lost_cnt_d;
  logic          run_loss;

  // Two-flop synchroniser: pll_locked is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      lk_q    <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    run_loss = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_q) begin
          state_d = S_STABLE;
        end
      end

      S_STABLE: begin
        if (!lk_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = '0;
        // A lock loss wins over any delay strobe arriving in the same cycle.
        if (!lk_q) begin
          state_d  = S_WAIT_LOCK;
          run_loss = 1'b1;
        end else if (bus.delay_inc && !bus.delay_dec && (delay_q != 4'd15)) begin
          delay_d = delay_q + 4'd1;
          state_d = S_SETTLE;
        end else if (bus.delay_dec && !bus.delay_inc && (delay_q != 4'd0)) begin
          delay_d = delay_q - 4'd1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lock_lost_d = lock_lost_q;
    lost_cnt_d  = lost_cnt_q;
    // A clear coinciding with a loss leaves exactly that one loss recorded.
    if (run_loss) begin
      lock_lost_d = 1'b1;
      if (bus.clear_status) begin
        lost_cnt_d = 8'd1;
      end else if (lost_cnt_q != 8'hFF) begin
        lost_cnt_d = lost_cnt_q + 8'd1;
      end
    end else if (bus.clear_status) begin
      lock_lost_d = 1'b0;
      lost_cnt_d  = 8'd0;
    end
  end

  always_comb begin
    hrst_d  = (state_d != S_RUN);
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      delay_q     <= DELAY_INIT;
      hrst_q      <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      lost_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      hrst_q      <= hrst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign bus.pll_delay  = delay_q;
  assign bus.hdmi_reset = hrst_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.lost_count = lost_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_pll_supervisor.sv
// ============================================================================
// Module      : tb_hdmi_pll_supervisor
// Description : Directed and randomised checks of hdmi_pll_supervisor against
//               a countdown-style reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdmi_pll_supervisor;

  localparam int STABLE = 16;
  localparam int SETTLE = 8;
  localparam int DINIT  = 0;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hdmi_pll_supervisor_if bus();

  hdmi_pll_supervisor #(
    .STABLE_CYCLES (STABLE),
    .SETTLE_CYCLES (SETTLE),
    .DELAY_INIT    (4'(DINIT))
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining lock cycles before release, remaining settle cycles.
  int m_p1, m_p2;
  int m_run, m_settle, m_need;
  int m_delay, m_lost, m_ll;

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0;
    m_run = 0; m_settle = 0; m_need = STABLE + 1;
    m_delay = DINIT; m_lost = 0; m_ll = 0;
  endtask

  task automatic model_edge();
    int lk, loss;
    if (reset) begin
      model_reset();
      return;
    end
    lk   = m_p2;
    loss = 0;
    if (m_run != 0) begin
      if (lk == 0) begin
        m_run = 0; loss = 1; m_need = STABLE + 1;
      end else if (bus.delay_inc != bus.delay_dec) begin
        if (bus.delay_inc && m_delay < 15) begin
          m_delay++; m_run = 0; m_settle = SETTLE;
        end else if (bus.delay_dec && m_delay > 0) begin
          m_delay--; m_run = 0; m_settle = SETTLE;
        end
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) m_need = STABLE;
    end else if (lk != 0) begin
      m_need--;
      if (m_need == 0) m_run = 1;
    end else begin
      m_need = STABLE + 1;
    end
    if (loss != 0) begin
      m_ll   = 1;
      m_lost = bus.clear_status ? 1 : ((m_lost < 255) ? m_lost + 1 : 255);
    end else if (bus.clear_status) begin
      m_ll = 0; m_lost = 0;
    end
    m_p2 = m_p1;
    m_p1 = int'(bus.pll_locked);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cyc_pll_delay",  32'(bus.pll_delay),  32'(m_delay));
    check("cyc_hdmi_reset", 32'(bus.hdmi_reset), (m_run != 0) ? 32'd0 : 32'd1);
    check("cyc_ready",      32'(bus.ready),      32'(m_run));
    check("cyc_lock_lost",  32'(bus.lock_lost),  32'(m_ll));
    check("cyc_lost_count", 32'(bus.lost_count), 32'(m_lost));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("ready_reached", 32'(bus.ready), 32'd1);
  endtask

  task automatic pulse(input logic inc, input logic dec);
    bus.delay_inc = inc;
    bus.delay_dec = dec;
    step();
    bus.delay_inc = 1'b0;
    bus.delay_dec = 1'b0;
  endtask

  // Drop lock so the RUN-state loss lands on the same edge as the given strobes.
  task automatic loss_with(input logic inc, input logic dec, input logic clr);
    bus.pll_locked = 1'b0;
    step();
    step();
    bus.delay_inc    = inc;
    bus.delay_dec    = dec;
    bus.clear_status = clr;
    step();
    bus.delay_inc    = 1'b0;
    bus.delay_dec    = 1'b0;
    bus.clear_status = 1'b0;
    bus.pll_locked   = 1'b1;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    model_reset();
    reset            = 1'b1;
    bus.pll_locked   = 1'b0;
    bus.delay_inc    = 1'b0;
    bus.delay_dec    = 1'b0;
    bus.clear_status = 1'b0;
    step();
    step();
    check("rst_hdmi_reset", 32'(bus.hdmi_reset), 32'd1);
    check("rst_ready",      32'(bus.ready),      32'd0);
    check("rst_pll_delay",  32'(bus.pll_delay),  32'(DINIT));
    reset = 1'b0;

    // Glitch during qualification, then a clean release.
    bus.pll_locked = 1'b1;
    repeat (12) step();
    bus.pll_locked = 1'b0;
    repeat (3) step();
    check("glitch_not_ready", 32'(bus.ready), 32'd0);
    bus.pll_locked = 1'b1;
    wait_ready(n);
    check("release_latency", 32'(n), 32'(2 + 1 + STABLE));
    check("glitch_lost_count", 32'(bus.lost_count), 32'd0);

    // Single loss in RUN.
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.hdmi_reset !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("loss_latency", 32'(n), 32'd3);
    check("loss_ready",   32'(bus.ready),      32'd0);
    check("loss_sticky",  32'(bus.lock_lost),  32'd1);
    check("loss_count",   32'(bus.lost_count), 32'd1);
    bus.pll_locked = 1'b1;
    wait_ready(n);
    check("relock_latency", 32'(n), 32'(2 + 1 + STABLE));

    // Delay step and re-qualification.
    pulse(1'b1, 1'b0);
    n = 0;
    while (bus.hdmi_reset === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check("step_hold_cycles", 32'(n), 32'(SETTLE + STABLE));
    check("step_delay",       32'(bus.pll_delay), 32'd1);
    check("step_ready",       32'(bus.ready),     32'd1);
    pulse(1'b0, 1'b1);
    wait_ready(n);
    pulse(1'b0, 1'b1);
    check("dec_at_zero_delay", 32'(bus.pll_delay), 32'd0);
    check("dec_at_zero_ready", 32'(bus.ready),     32'd1);

    // Reset in the middle of SETTLE with a recorded loss outstanding.
    repeat (4) begin
      pulse(1'b1, 1'b0);
      wait_ready(n);
    end
    pulse(1'b1, 1'b0);
    check("pre_rst_delay", 32'(bus.pll_delay), 32'd5);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midsettle_delay", 32'(bus.pll_delay),  32'(DINIT));
    check("midsettle_hrst",  32'(bus.hdmi_reset), 32'd1);
    check("midsettle_ll",    32'(bus.lock_lost),  32'd0);
    check("midsettle_lost",  32'(bus.lost_count), 32'd0);
    wait_ready(n);

    // Saturating loss counter, then clear.
    repeat (300) begin
      bus.pll_locked = 1'b0;
      repeat (3) step();
      bus.pll_locked = 1'b1;
      wait_ready(n);
    end
    check("sat_lost_count", 32'(bus.lost_count), 32'd255);
    check("sat_lock_lost",  32'(bus.lock_lost),  32'd1);
    bus.clear_status = 1'b1;
    step();
    bus.clear_status = 1'b0;
    check("clear_lost_count", 32'(bus.lost_count), 32'd0);
    check("clear_lock_lost",  32'(bus.lock_lost),  32'd0);

    // Upper delay limit and simultaneous strobes.
    repeat (15) begin
      pulse(1'b1, 1'b0);
      wait_ready(n);
    end
    check("ramp_delay", 32'(bus.pll_delay), 32'd15);
    pulse(1'b1, 1'b0);
    check("inc_at_max_delay", 32'(bus.pll_delay), 32'd15);
    check("inc_at_max_ready", 32'(bus.ready),     32'd1);
    pulse(1'b1, 1'b1);
    check("both_delay", 32'(bus.pll_delay), 32'd15);
    check("both_ready", 32'(bus.ready),     32'd1);
    pulse(1'b0, 1'b1);
    wait_ready(n);
    loss_with(1'b1, 1'b0, 1'b0);
    check("loss_inc_delay", 32'(bus.pll_delay),  32'd14);
    check("loss_inc_lost",  32'(bus.lost_count), 32'd1);
    wait_ready(n);
    loss_with(1'b0, 1'b0, 1'b0);
    check("loss_two", 32'(bus.lost_count), 32'd2);
    wait_ready(n);
    loss_with(1'b0, 1'b0, 1'b1);
    check("clear_loss_lost", 32'(bus.lost_count), 32'd1);
    check("clear_loss_ll",   32'(bus.lock_lost),  32'd1);
    wait_ready(n);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
      bus.delay_inc    = ($urandom_range(0, 7) == 0);
      bus.delay_dec    = ($urandom_range(0, 7) == 0);
      bus.clear_status = ($urandom_range(0, 31) == 0);
      reset            = ($urandom_range(0, 599) == 0);
      step();
    end
    reset            = 1'b0;
    bus.delay_inc    = 1'b0;
    bus.delay_dec    = 1'b0;
    bus.clear_status = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
